// File: rtl/store_drain_buffer.sv
// store_drain_buffer
//   Posted-store queue between the core memory stage and the data memory.
//   Stores are accepted into a DEPTH-entry circular queue and drained one
//   per cycle into the memory write port. Loads are checked against the
//   queued stores so the core never observes stale memory contents.
//
//   Optional feature macro: STORE_FWD_EN
//     defined   : loads forward from the youngest matching queued store,
//                 the drain yields the port to loads, ldStall is tied low.
//     undefined : no compare logic; a load with stores pending is stalled
//                 while the queue keeps draining until it is empty.
//
// Ports
//   clk, reset      clock, synchronous active-low reset
//   stValid/stReady store handshake; stAddr/stData store byte address/data
//   ldReq, ldAddr   load this cycle (claims the memory port), byte address
//   ldHit, ldData   forwarded store data for the load
//   ldStall         core must retry the load next cycle
//   memWrEn/memAddr/memData  data memory write port
//   empty, count    queue occupancy
module store_drain_buffer #(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int DMEMADDRBITS   = 13,
  parameter int DMEMWORDBITS   = 2,
  parameter int DEPTH          = 4,
  parameter int PTR_BITS       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stValid,
  output logic                      stReady,
  input  logic [DATA_BIT_WIDTH-1:0] stAddr,
  input  logic [DATA_BIT_WIDTH-1:0] stData,
  input  logic                      ldReq,
  input  logic [DATA_BIT_WIDTH-1:0] ldAddr,
  output logic                      ldHit,
  output logic [DATA_BIT_WIDTH-1:0] ldData,
  output logic                      ldStall,
  output logic                      memWrEn,
  output logic [DATA_BIT_WIDTH-1:0] memAddr,
  output logic [DATA_BIT_WIDTH-1:0] memData,
  output logic                      empty,
  output logic [PTR_BITS:0]         count
);

  typedef struct packed {
    logic [DATA_BIT_WIDTH-1:0] addr;
    logic [DATA_BIT_WIDTH-1:0] data;
  } ent_t;

  localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS+1)'(DEPTH);

  ent_t [DEPTH-1:0]    ent;
  logic [PTR_BITS-1:0] head, tail;
  logic [PTR_BITS:0]   cnt;
  logic                push, pop, pending;

  // Occupancy alone decides full/empty; the pointers just wrap.
  assign pending = reset && (cnt != '0);
  assign stReady = reset && (cnt != FULL_CNT);
  assign push    = stValid && stReady;
  assign pop     = memWrEn;

  // The count register only clears on the reset edge, so the visible
  // occupancy is forced to zero for the whole time reset is held low.
  assign count   = reset ? cnt : '0;
  assign empty   = !pending;

  assign memAddr = ent[head].addr;
  assign memData = ent[head].data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage carries no reset: contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) ent[tail] <= '{addr: stAddr, data: stData};
  end

  logic unused_ldaddr;
  assign unused_ldaddr = ^ldAddr;

`ifdef STORE_FWD_EN
  logic [DEPTH-1:0] match;

  // Raw word-address compare per entry; validity is applied by age below.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match[i] = (ent[i].addr[DMEMADDRBITS-1:DMEMWORDBITS] ==
                       ldAddr[DMEMADDRBITS-1:DMEMWORDBITS]);
  end

  // Walk entries oldest to youngest so the youngest valid match wins.
  // The head entry stays valid even while it is being popped.
  always_comb begin
    logic [PTR_BITS-1:0] idx;
    ldHit  = 1'b0;
    ldData = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_BITS'(k);
      if (reset && ((PTR_BITS+1)'(k) < cnt) && match[idx]) begin
        ldHit  = 1'b1;
        ldData = ent[idx].data;
      end
    end
  end

  assign ldStall = 1'b0;
  assign memWrEn = pending && !ldReq;
`else
  // Without forwarding the load waits for the queue to empty, so the
  // drain keeps the port even while a load is being held.
  assign ldHit   = 1'b0;
  assign ldData  = '0;
  assign ldStall = ldReq && pending;
  assign memWrEn = pending;
`endif

endmodule

// File: tb/tb_store_drain_buffer.sv
module tb_store_drain_buffer;
  localparam int W = 32;
`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         stValid = 1'b0, ldReq = 1'b0;
  logic [W-1:0] stAddr = '0, stData = '0, ldAddr = '0;
  logic         stReady, ldHit, ldStall, memWrEn, empty;
  logic [W-1:0] ldData, memAddr, memData;
  logic [2:0]   count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  store_drain_buffer dut (
    .clk(clk), .reset(reset),
    .stValid(stValid), .stReady(stReady), .stAddr(stAddr), .stData(stData),
    .ldReq(ldReq), .ldAddr(ldAddr), .ldHit(ldHit), .ldData(ldData),
    .ldStall(ldStall), .memWrEn(memWrEn), .memAddr(memAddr),
    .memData(memData), .empty(empty), .count(count)
  );

  // Reference model: a plain FIFO of {addr,data}.
  typedef struct { logic [W-1:0] a; logic [W-1:0] d; } ent_t;
  ent_t q[$];

  always @(posedge clk) begin
    if (!reset) q.delete();
    else begin
      bit do_pop, do_push;
      do_pop  = (q.size() != 0) && (!FWD || !ldReq);
      do_push = stValid && (q.size() != 4);
      if (do_pop) q.delete(0);
      if (do_push) q.push_back('{stAddr, stData});
    end
  end

  logic         e_ready, e_wr, e_hit, e_stall, e_empty;
  logic [W-1:0] e_addr, e_data, e_ldata;
  logic [2:0]   e_count;

  function automatic bit wmatch(logic [W-1:0] x, logic [W-1:0] y);
    return x[12:2] == y[12:2];
  endfunction

  function automatic void compute_exp();
    e_ready = 0; e_wr = 0; e_hit = 0; e_stall = 0; e_empty = 1;
    e_addr = '0; e_data = '0; e_ldata = '0; e_count = '0;
    if (reset) begin
      e_count = 3'(q.size());
      e_empty = (q.size() == 0);
      e_ready = (q.size() != 4);
      e_wr    = (q.size() != 0) && (!FWD || !ldReq);
      if (q.size() != 0) begin e_addr = q[0].a; e_data = q[0].d; end
      if (FWD) begin
        for (int i = q.size() - 1; i >= 0; i--)
          if (wmatch(q[i].a, ldAddr)) begin e_hit = 1; e_ldata = q[i].d; break; end
      end else begin
        e_stall = ldReq && (q.size() != 0);
      end
    end
  endfunction

  // Drive one cycle of inputs just after the edge, then settle at negedge.
  task automatic step(input logic rst, input logic sv, input logic [W-1:0] sa,
                      input logic [W-1:0] sd, input logic lr, input logic [W-1:0] la);
    @(posedge clk); #1;
    reset = rst; stValid = sv; stAddr = sa; stData = sd; ldReq = lr; ldAddr = la;
    @(negedge clk);
    compute_exp();
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h10, 32'h5, 1, 32'h10);
    n_checks += 6;
    if (stReady !== 1'b0) begin n_fail++; $display("FAIL rst_stReady got=%0b exp=0", stReady); end
    if (memWrEn !== 1'b0) begin n_fail++; $display("FAIL rst_memWrEn got=%0b exp=0", memWrEn); end
    if (empty !== 1'b1)   begin n_fail++; $display("FAIL rst_empty got=%0b exp=1", empty); end
    if (count !== 3'd0)   begin n_fail++; $display("FAIL rst_count got=%0d exp=0", count); end
    if (ldHit !== 1'b0)   begin n_fail++; $display("FAIL rst_ldHit got=%0b exp=0", ldHit); end
    if (ldStall !== 1'b0) begin n_fail++; $display("FAIL rst_ldStall got=%0b exp=0", ldStall); end
    step(1, 0, 0, 0, 0, 0);
    n_checks += 4;
    if (stReady !== 1'b1) begin n_fail++; $display("FAIL idle_stReady got=%0b exp=1", stReady); end
    if (count !== 3'd0)   begin n_fail++; $display("FAIL idle_count got=%0d exp=0", count); end
    if (empty !== 1'b1)   begin n_fail++; $display("FAIL idle_empty got=%0b exp=1", empty); end
    if (memWrEn !== 1'b0) begin n_fail++; $display("FAIL idle_memWrEn got=%0b exp=0", memWrEn); end
  endtask

  task automatic test_drain();
    step(1, 1, 32'h10, 32'hAAAA0001, 0, 0);
    n_checks += 2;
    if (memWrEn !== 1'b0) begin n_fail++; $display("FAIL drain0_wr got=%0b exp=0", memWrEn); end
    if (count !== 3'd0)   begin n_fail++; $display("FAIL drain0_count got=%0d exp=0", count); end
    step(1, 1, 32'h14, 32'hAAAA0002, 0, 0);
    n_checks += 3;
    if (memWrEn !== 1'b1) begin n_fail++; $display("FAIL drain1_wr got=%0b exp=1", memWrEn); end
    if (memAddr !== 32'h10) begin n_fail++; $display("FAIL drain1_addr got=%h exp=10", memAddr); end
    if (memData !== 32'hAAAA0001) begin n_fail++; $display("FAIL drain1_data got=%h exp=aaaa0001", memData); end
    step(1, 0, 0, 0, 0, 0);
    n_checks += 4;
    if (memWrEn !== 1'b1) begin n_fail++; $display("FAIL drain2_wr got=%0b exp=1", memWrEn); end
    if (memAddr !== 32'h14) begin n_fail++; $display("FAIL drain2_addr got=%h exp=14", memAddr); end
    if (memData !== 32'hAAAA0002) begin n_fail++; $display("FAIL drain2_data got=%h exp=aaaa0002", memData); end
    if (count !== 3'd1) begin n_fail++; $display("FAIL drain2_count got=%0d exp=1", count); end
    step(1, 0, 0, 0, 0, 0);
    n_checks += 3;
    if (count !== 3'd0)   begin n_fail++; $display("FAIL drain3_count got=%0d exp=0", count); end
    if (memWrEn !== 1'b0) begin n_fail++; $display("FAIL drain3_wr got=%0b exp=0", memWrEn); end
    if (empty !== 1'b1)   begin n_fail++; $display("FAIL drain3_empty got=%0b exp=1", empty); end
  endtask

  task automatic fill4();
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 32'h40 + 32'(4*k), 32'hB000 + 32'(k), 1, 32'h20);
      n_checks += 2;
      if (count !== 3'(k)) begin n_fail++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, count, k); end
      if (stReady !== 1'b1) begin n_fail++; $display("FAIL fill_ready k=%0d got=%0b exp=1", k, stReady); end
    end
  endtask

  task automatic test_fill();
    fill4();
    step(1, 1, 32'h50, 32'hDEAD, 1, 32'h20);
    n_checks += 3;
    if (count !== 3'd4)   begin n_fail++; $display("FAIL full_count got=%0d exp=4", count); end
    if (stReady !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%0b exp=0", stReady); end
    if (memWrEn !== 1'b0) begin n_fail++; $display("FAIL full_wr got=%0b exp=0", memWrEn); end
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 0, 0, 0);
      n_checks += 4;
      if (memWrEn !== 1'b1) begin n_fail++; $display("FAIL fifo_wr k=%0d got=%0b exp=1", k, memWrEn); end
      if (memAddr !== 32'h40 + 32'(4*k)) begin n_fail++; $display("FAIL fifo_addr k=%0d got=%h", k, memAddr); end
      if (memData !== 32'hB000 + 32'(k)) begin n_fail++; $display("FAIL fifo_data k=%0d got=%h", k, memData); end
      if (count !== 3'(4-k)) begin n_fail++; $display("FAIL fifo_count k=%0d got=%0d exp=%0d", k, count, 4-k); end
    end
    step(1, 0, 0, 0, 0, 0);
    n_checks += 2;
    if (count !== 3'd0)   begin n_fail++; $display("FAIL fifo_end_count got=%0d exp=0", count); end
    if (memWrEn !== 1'b0) begin n_fail++; $display("FAIL fifo_end_wr got=%0b exp=0", memWrEn); end
  endtask

  task automatic test_fwd();
    step(1, 1, 32'h30, 32'h1111, 1, 32'h100);
    step(1, 1, 32'h32, 32'h2222, 1, 32'h100);
    n_checks += 1;
    if (ldHit !== 1'b0) begin n_fail++; $display("FAIL fwd_miss_hit got=%0b exp=0", ldHit); end
    step(1, 0, 0, 0, 1, 32'h31);
    n_checks += 4;
    if (ldHit !== 1'b1) begin n_fail++; $display("FAIL fwd_hit got=%0b exp=1", ldHit); end
    if (ldData !== 32'h2222) begin n_fail++; $display("FAIL fwd_data got=%h exp=2222", ldData); end
    if (ldStall !== 1'b0) begin n_fail++; $display("FAIL fwd_stall got=%0b exp=0", ldStall); end
    if (memWrEn !== 1'b0) begin n_fail++; $display("FAIL fwd_wr got=%0b exp=0", memWrEn); end
    step(1, 0, 0, 0, 1, 32'h36);
    n_checks += 1;
    if (ldHit !== 1'b0) begin n_fail++; $display("FAIL fwd_nextword got=%0b exp=0", ldHit); end
    step(1, 0, 0, 0, 1, 32'h2030);
    n_checks += 2;
    if (ldHit !== 1'b1) begin n_fail++; $display("FAIL fwd_highbits got=%0b exp=1", ldHit); end
    if (ldData !== 32'h2222) begin n_fail++; $display("FAIL fwd_highbits_data got=%h exp=2222", ldData); end
    step(1, 0, 0, 0, 0, 0);
    n_checks += 1;
    if (memAddr !== 32'h30) begin n_fail++; $display("FAIL fwd_drain0 got=%h exp=30", memAddr); end
    step(1, 0, 0, 0, 0, 0);
    n_checks += 1;
    if (memAddr !== 32'h32) begin n_fail++; $display("FAIL fwd_drain1 got=%h exp=32", memAddr); end
    step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_full_pop_reset();
    fill4();
    step(1, 1, 32'h60, 32'hBEEF, 0, 0);
    n_checks += 2;
    if (stReady !== 1'b0) begin n_fail++; $display("FAIL fullpop_ready got=%0b exp=0", stReady); end
    if (memWrEn !== 1'b1) begin n_fail++; $display("FAIL fullpop_wr got=%0b exp=1", memWrEn); end
    step(1, 0, 0, 0, 1, 32'h20);
    n_checks += 1;
    if (count !== 3'd3) begin n_fail++; $display("FAIL fullpop_count got=%0d exp=3", count); end
    step(0, 0, 0, 0, 0, 0);
    n_checks += 2;
    if (count !== 3'd0)   begin n_fail++; $display("FAIL midrst_count got=%0d exp=0", count); end
    if (memWrEn !== 1'b0) begin n_fail++; $display("FAIL midrst_wr got=%0b exp=0", memWrEn); end
    step(1, 0, 0, 0, 0, 0);
    n_checks += 3;
    if (count !== 3'd0)   begin n_fail++; $display("FAIL postrst_count got=%0d exp=0", count); end
    if (memWrEn !== 1'b0) begin n_fail++; $display("FAIL postrst_wr got=%0b exp=0", memWrEn); end
    if (empty !== 1'b1)   begin n_fail++; $display("FAIL postrst_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_stall();
    step(1, 1, 32'h50, 32'h7777, 0, 0);
    step(1, 0, 0, 0, 1, 32'h50);
    n_checks += 4;
    if (ldStall !== 1'b1) begin n_fail++; $display("FAIL stall_on got=%0b exp=1", ldStall); end
    if (memWrEn !== 1'b1) begin n_fail++; $display("FAIL stall_wr got=%0b exp=1", memWrEn); end
    if (ldHit !== 1'b0)   begin n_fail++; $display("FAIL stall_hit got=%0b exp=0", ldHit); end
    if (ldData !== '0)    begin n_fail++; $display("FAIL stall_ldData got=%h exp=0", ldData); end
    step(1, 0, 0, 0, 1, 32'h50);
    n_checks += 3;
    if (ldStall !== 1'b0) begin n_fail++; $display("FAIL stall_off got=%0b exp=0", ldStall); end
    if (memWrEn !== 1'b0) begin n_fail++; $display("FAIL stall_off_wr got=%0b exp=0", memWrEn); end
    if (empty !== 1'b1)   begin n_fail++; $display("FAIL stall_off_empty got=%0b exp=1", empty); end
    // A queued store is lost across reset.
    step(1, 1, 32'h54, 32'h8888, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    n_checks += 2;
    if (count !== 3'd0)   begin n_fail++; $display("FAIL stall_rst_count got=%0d exp=0", count); end
    if (memWrEn !== 1'b0) begin n_fail++; $display("FAIL stall_rst_wr got=%0b exp=0", memWrEn); end
  endtask

  function automatic logic [W-1:0] rnd_addr();
    return (32'($urandom_range(0, 1)) << 13) | (32'h40 + (32'($urandom_range(0, 7)) << 2))
           | 32'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      step($urandom_range(0, 59) != 0, $urandom_range(0, 9) < 7, rnd_addr(), $urandom(),
           $urandom_range(0, 1) == 1, rnd_addr());
      n_checks += 5;
      if (stReady !== e_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, stReady, e_ready); end
      if (memWrEn !== e_wr)    begin n_fail++; $display("FAIL rnd_wr c=%0d got=%0b exp=%0b", c, memWrEn, e_wr); end
      if (count !== e_count)   begin n_fail++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, e_count); end
      if (empty !== e_empty)   begin n_fail++; $display("FAIL rnd_empty c=%0d got=%0b exp=%0b", c, empty, e_empty); end
      if (ldStall !== e_stall) begin n_fail++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, ldStall, e_stall); end
      if (e_wr) begin
        n_checks += 2;
        if (memAddr !== e_addr) begin n_fail++; $display("FAIL rnd_maddr c=%0d got=%h exp=%h", c, memAddr, e_addr); end
        if (memData !== e_data) begin n_fail++; $display("FAIL rnd_mdata c=%0d got=%h exp=%h", c, memData, e_data); end
      end
      if (ldReq || !reset) begin
        n_checks += 1;
        if (ldHit !== e_hit) begin n_fail++; $display("FAIL rnd_hit c=%0d got=%0b exp=%0b", c, ldHit, e_hit); end
      end
      if (e_hit || !FWD) begin
        n_checks += 1;
        if (ldData !== e_ldata) begin n_fail++; $display("FAIL rnd_ldata c=%0d got=%h exp=%h", c, ldData, e_ldata); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_drain();
`ifdef STORE_FWD_EN
    test_fill();
    test_fwd();
    test_full_pop_reset();
`else
    test_stall();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
